csr_bus_master: RTL

Initiator for the 8-bit CSR register bus (en/we/addr/wdata/rdata, one-cycle registered read data). It accepts read/write requests on a valid/ready request channel, buffers them in a small FIFO, and drives single-cycle bus accesses. It returns one response per request on a valid/ready response channel. It sits between the DPI/testbench-facing command source and any CSR responder block.

---
 rtl/csr_master_pkg.sv | 13 +
 rtl/csr_req_fifo.sv | 45 ++++
 rtl/csr_bus_master.sv | 103 ++++++++++
 3 files changed

// File: rtl/csr_master_pkg.sv
// csr_master_pkg: shared widths, request record and FSM states for the CSR bus master
package csr_master_pkg;
    localparam int AW = 5;
    localparam int DW = 8;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } csr_req_t;

    typedef enum logic [2:0] {IDLE, ACCESS, RB_ACCESS, WAIT, RSP} csr_mst_state_e;
endpackage

// File: rtl/csr_req_fifo.sv
// csr_req_fifo: synchronous request FIFO, power-of-two depth, pointers wrap naturally
module csr_req_fifo
    import csr_master_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  csr_req_t                 din,
    input  logic                     pop,
    output csr_req_t                 dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    csr_req_t        mem [DEPTH];
    logic [PW-1:0]   wp, rp;
    logic            do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rp];

    // storage needs no reset; only entries below count are ever read
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/csr_bus_master.sv
// csr_bus_master: queues read/write requests and runs them as single-cycle CSR bus accesses
// Optional CSR_MASTER_READBACK_EN: every write is verified by a readback access, mismatch flags rsp_err
module csr_bus_master
    import csr_master_pkg::*;
#(
    parameter int AW        = csr_master_pkg::AW,
    parameter int DW        = csr_master_pkg::DW,
    parameter int REQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_write,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          bus_en,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata
);
    csr_req_t                        in_req, head;
    logic                            full, empty, pop;
    logic [$clog2(REQ_DEPTH):0]      count;
    csr_mst_state_e                  state, next;

    assign in_req    = {req_write, req_addr, req_wdata};
    assign req_ready = count != ($clog2(REQ_DEPTH)+1)'(REQ_DEPTH);
    assign pop       = !empty && (state == IDLE || (state == RSP && rsp_ready));
    assign rsp_valid = state == RSP;

    csr_req_fifo #(.DEPTH(REQ_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && !full),
        .din   (in_req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    // next-state: a response handshake chains straight into the next queued access
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = empty ? IDLE : ACCESS;
`ifdef CSR_MASTER_READBACK_EN
            ACCESS:    next = bus_we ? RB_ACCESS : WAIT;
            RB_ACCESS: next = WAIT;
`else
            ACCESS:    next = bus_we ? RSP : WAIT;
`endif
            WAIT:      next = RSP;
            RSP:       next = !rsp_ready ? RSP : empty ? IDLE : ACCESS;
            default:   next = IDLE;
        endcase
    end

    // bus and response registers; bus fields hold between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            bus_en <= next == ACCESS || next == RB_ACCESS;
            if (pop) begin
                bus_we    <= head.write;
                bus_addr  <= head.addr;
                bus_wdata <= head.wdata;
                rsp_write <= head.write;
                rsp_rdata <= '0;
            end
            if (next == RB_ACCESS) bus_we <= 1'b0;
            if (state == WAIT) rsp_rdata <= bus_rdata;
        end
    end

`ifdef CSR_MASTER_READBACK_EN
    // readback compare against the data that was just written
    always_ff @(posedge clk) begin
        if (rst || pop) rsp_err <= 1'b0;
        else if (state == WAIT) rsp_err <= rsp_write && (bus_rdata != bus_wdata);
    end
`else
    assign rsp_err = 1'b0;
`endif
endmodule
